// File: rtl/e15_prog_loader.sv
// e15_prog_loader: nibble-stream program loader filling a 16 x 12-bit instruction
// memory, with checksum verification and a processor hold until a good load.
module e15_prog_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        in_ready,
    input  logic [3:0]  fetch_addr,
    output logic [11:0] fetch_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        load_ok,
    output logic        load_err,
    output logic [4:0]  words_loaded
);
    typedef enum logic [2:0] {IDLE, GET_LEN, GET_HI, GET_MID, GET_LO, GET_CHK} state_t;

    state_t      state_q, state_d;
    logic [11:0] mem_q [16];
    logic [11:0] mem_d [16];
    logic [3:0]  addr_q, addr_d, len_q, len_d, sum_q, sum_d, hi_q, hi_d, mid_q, mid_d;
    logic [4:0]  wl_q, wl_d;
    logic        cpu_hold_q, cpu_hold_d, done_q, done_d, load_ok_q, load_ok_d, load_err_q, load_err_d;
    logic        acc;

    assign acc = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i < 16; i++) mem_q[i] <= 12'h000;
            addr_q     <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            hi_q       <= '0;
            mid_q      <= '0;
            wl_q       <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            wl_q       <= wl_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            load_ok_q  <= load_ok_d;
            load_err_q <= load_err_d;
        end
    end

    // start wins over a nibble offered in the same cycle
    always_comb begin
        state_d = state_q;
        if (start) state_d = GET_LEN;
        else if (acc) begin
            case (state_q)
                GET_LEN: state_d = GET_HI;
                GET_HI:  state_d = GET_MID;
                GET_MID: state_d = GET_LO;
                GET_LO:  state_d = (addr_q == len_q) ? GET_CHK : GET_HI;
                GET_CHK: state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mem_d      = mem_q;
        addr_d     = addr_q;
        len_d      = len_q;
        sum_d      = sum_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        wl_d       = wl_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        load_ok_d  = load_ok_q;
        load_err_d = load_err_q;
        if (start) begin
            addr_d     = '0;
            sum_d      = '0;
            wl_d       = '0;
            cpu_hold_d = 1'b1;
            load_ok_d  = 1'b0;
            load_err_d = 1'b0;
        end else if (acc) begin
            sum_d = (state_q == GET_CHK) ? sum_q : sum_q + in_data;
            case (state_q)
                GET_LEN: len_d = in_data;
                GET_HI:  hi_d = in_data;
                GET_MID: mid_d = in_data;
                GET_LO: begin
                    mem_d[addr_q] = {hi_q, mid_q, in_data};
                    wl_d          = wl_q + 5'd1;
                    addr_d        = (addr_q == len_q) ? addr_q : addr_q + 4'd1;
                end
                GET_CHK: begin
                    done_d     = 1'b1;
                    load_ok_d  = (in_data == sum_q);
                    load_err_d = (in_data != sum_q);
                    cpu_hold_d = (in_data != sum_q);
                end
                default: done_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state_q != IDLE);
        fetch_data   = mem_q[fetch_addr];
        cpu_hold     = cpu_hold_q;
        done         = done_q;
        load_ok      = load_ok_q;
        load_err     = load_err_q;
        words_loaded = wl_q;
    end
endmodule

// File: tb/tb_e15_prog_loader.sv
// tb_e15_prog_loader: randomized scenarios against a word-level model of the
// loaded program image and the expected checksum of each stream.
module tb_e15_prog_loader;
    typedef logic [3:0] nib_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_ready;
    logic [3:0]  fetch_addr = '0;
    logic [11:0] fetch_data;
    logic        cpu_hold, done, load_ok, load_err;
    logic [4:0]  words_loaded;

    int checks = 0;
    int fails = 0;
    logic [11:0] model_mem [16];

    e15_prog_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .cpu_hold(cpu_hold), .done(done), .load_ok(load_ok), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic do_start(input logic v, input logic [3:0] d);
        start = 1'b1; in_valid = v; in_data = d;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    // Stream: LEN=N-1, 3 nibbles per word MSB first, then the mod-16 sum (or a wrong one).
    task automatic make_stream(input int n, input logic [11:0] w [16], input bit bad, output nib_q_t s);
        int sum;
        logic [3:0] chk;
        s = {};
        s.push_back(4'(n - 1));
        sum = n - 1;
        for (int i = 0; i < n; i++) begin
            for (int k = 2; k >= 0; k--) begin
                s.push_back(4'((w[i] >> (4 * k)) & 12'hF));
                sum += (w[i] >> (4 * k)) & 12'hF;
            end
        end
        chk = 4'(sum % 16);
        if (bad) chk = 4'((sum + 1 + $urandom_range(14)) % 16);
        s.push_back(chk);
    endtask

    // Drives the nibbles with optional idle gaps; counts done pulses seen before the last nibble.
    task automatic play(input nib_q_t s, input int gap, output int early);
        int g;
        early = 0;
        foreach (s[i]) begin
            g = 0;
            while (gap > 0 && g < 6 && $urandom_range(99) < gap) begin
                in_valid = 1'b0; in_data = 4'($urandom);
                @(posedge clk); #1;
                if (done) early++;
                g++;
            end
            in_valid = 1'b1; in_data = s[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (done && i != s.size() - 1) early++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a); #1;
            checks++;
            if (fetch_data !== 12'h000) begin fails++; $display("FAIL reset_mem[%0d]: got %h expected 000", a, fetch_data); end
        end
        checks++;
        if ({cpu_hold, in_ready, load_ok, load_err, done, words_loaded} !== {1'b1, 4'b0, 5'd0}) begin
            fails++; $display("FAIL reset_flags: got hold=%b rdy=%b ok=%b err=%b done=%b wl=%0d expected 1 0 0 0 0 0",
                              cpu_hold, in_ready, load_ok, load_err, done, words_loaded);
        end
        for (int a = 0; a < 16; a++) model_mem[a] = 12'h000;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 4'hA;
        repeat (3) @(posedge clk);
        #1; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || words_loaded !== 5'd0 || done !== 1'b0) begin
            fails++; $display("FAIL idle_ignore: got rdy=%b wl=%0d done=%b expected 0 0 0", in_ready, words_loaded, done);
        end
    endtask

    task automatic test_single(input bit bad);
        logic [11:0] w [16];
        nib_q_t s;
        int early;
        w[0] = 12'h915;
        make_stream(1, w, 1'b0, s);
        if (bad) s[4] = 4'hE;
        do_start(1'b0, 4'h0);
        checks++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || load_ok !== 1'b0 || load_err !== 1'b0) begin
            fails++; $display("FAIL start_state: got rdy=%b hold=%b ok=%b err=%b expected 1 1 0 0", in_ready, cpu_hold, load_ok, load_err);
        end
        play(s, 0, early);
        model_mem[0] = 12'h915;
        checks++;
        if (early !== 0 || done !== 1'b1) begin
            fails++; $display("FAIL done_timing: got early=%0d done=%b expected 0 1", early, done);
        end
        checks++;
        if (load_ok !== !bad || load_err !== bad || cpu_hold !== bad || words_loaded !== 5'd1) begin
            fails++; $display("FAIL single_result(bad=%0d): got ok=%b err=%b hold=%b wl=%0d expected %b %b %b 1",
                              bad, load_ok, load_err, cpu_hold, words_loaded, !bad, bad, bad);
        end
        fetch_addr = 4'd0; #1;
        checks++;
        if (fetch_data !== 12'h915) begin fails++; $display("FAIL single_mem: got %h expected 915", fetch_data); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL done_pulse: got done=%b rdy=%b expected 0 0", done, in_ready);
        end
    endtask

    task automatic run_and_check(input string name, input int n, input bit bad, input int gap);
        logic [11:0] w [16];
        nib_q_t s;
        int early;
        for (int i = 0; i < 16; i++) w[i] = 12'($urandom);
        make_stream(n, w, bad, s);
        do_start(1'b0, 4'h0);
        play(s, gap, early);
        for (int i = 0; i < n; i++) model_mem[i] = w[i];
        checks++;
        if (early !== 0 || done !== 1'b1 || load_ok !== !bad || load_err !== bad || cpu_hold !== bad || words_loaded !== 5'(n)) begin
            fails++; $display("FAIL %s(n=%0d bad=%0d): got early=%0d done=%b ok=%b err=%b hold=%b wl=%0d expected 0 1 %b %b %b %0d",
                              name, n, bad, early, done, load_ok, load_err, cpu_hold, words_loaded, !bad, bad, bad, n);
        end
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a); #1;
            checks++;
            if (fetch_data !== model_mem[a]) begin
                fails++; $display("FAIL %s_mem[%0d]: got %h expected %h", name, a, fetch_data, model_mem[a]);
            end
        end
    endtask

    task automatic test_full_load;
        run_and_check("full_load", 16, 1'b0, 35);
    endtask

    task automatic test_random_sessions;
        for (int r = 0; r < 8; r++)
            run_and_check("random", int'($urandom_range(1, 16)), ($urandom_range(3) == 0), int'($urandom_range(40)));
    endtask

    task automatic test_restart;
        logic [11:0] w [16];
        nib_q_t s;
        int early;
        w[0] = 12'($urandom); w[1] = 12'($urandom); w[2] = 12'($urandom);
        make_stream(3, w, 1'b0, s);
        s = s[0:4];
        do_start(1'b0, 4'h0);
        play(s, 0, early);
        model_mem[0] = w[0];
        checks++;
        if (cpu_hold !== 1'b1 || words_loaded !== 5'd1 || early !== 0) begin
            fails++; $display("FAIL abort_state: got hold=%b wl=%0d early=%0d expected 1 1 0", cpu_hold, words_loaded, early);
        end
        do_start(1'b1, 4'h5);
        checks++;
        if (cpu_hold !== 1'b1 || words_loaded !== 5'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL restart_state: got hold=%b wl=%0d done=%b rdy=%b expected 1 0 0 1", cpu_hold, words_loaded, done, in_ready);
        end
        w[0] = 12'h3C7;
        make_stream(1, w, 1'b0, s);
        play(s, 0, early);
        model_mem[0] = 12'h3C7;
        checks++;
        if (done !== 1'b1 || load_ok !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 5'd1) begin
            fails++; $display("FAIL restart_result: got done=%b ok=%b hold=%b wl=%0d expected 1 1 0 1", done, load_ok, cpu_hold, words_loaded);
        end
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a); #1;
            checks++;
            if (fetch_data !== model_mem[a]) begin
                fails++; $display("FAIL restart_mem[%0d]: got %h expected %h", a, fetch_data, model_mem[a]);
            end
        end
    endtask

    task automatic test_reset_mid;
        nib_q_t s;
        int early;
        s = {4'h2, 4'h7};
        do_start(1'b0, 4'h0);
        play(s, 0, early);
        in_valid = 1'b1; in_data = 4'h4;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || load_ok !== 1'b0 || load_err !== 1'b0 || words_loaded !== 5'd0) begin
            fails++; $display("FAIL reset_mid_flags: got hold=%b rdy=%b ok=%b err=%b wl=%0d expected 1 0 0 0 0",
                              cpu_hold, in_ready, load_ok, load_err, words_loaded);
        end
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a); #1;
            checks++;
            if (fetch_data !== 12'h000) begin fails++; $display("FAIL reset_mid_mem[%0d]: got %h expected 000", a, fetch_data); end
            model_mem[a] = 12'h000;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL reset_mid_idle: got rdy=%b hold=%b done=%b expected 0 1 0", in_ready, cpu_hold, done);
        end
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_full_load();
        test_restart();
        test_random_sessions();
        test_reset_mid();
        run_and_check("after_reset", 4, 1'b0, 20);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
